usb_tx_stuff_nrzi: RTL



---
 rtl/usb_tx_stuff_nrzi.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_stuff_nrzi.sv
// USB transmit back end: bit stuffing, NRZI encoding, EOP generation and
// transceiver line drive. Optional stuffed-bit counter output is enabled by
// defining USB_TX_STUFF_CNT_EN.
module usb_tx_stuff_nrzi #(
  parameter int unsigned STUFF_LEN      = 6,
  parameter int unsigned EOP_SE0_CYCLES = 2,
  parameter bit          LOW_SPEED      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bit_last,
  output logic       stall,
  output logic       dp,
  output logic       dm,
  output logic       oe,
`ifdef USB_TX_STUFF_CNT_EN
  output logic [7:0] stuff_cnt,
`endif
  output logic       eop_done
);

  localparam int unsigned CntW = $clog2(STUFF_LEN + 1);
  localparam int unsigned EopW = $clog2(EOP_SE0_CYCLES + 2);

  // {dp,dm} for the idle (J) and opposite (K) line states.
  localparam logic [1:0] LineJ = LOW_SPEED ? 2'b01 : 2'b10;
  localparam logic [1:0] LineK = LOW_SPEED ? 2'b10 : 2'b01;
  localparam logic [1:0] LineSe0 = 2'b00;

  typedef enum logic [1:0] {StIdle, StActive, StStuff, StEop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   ones_q, ones_d;
  logic [EopW-1:0]   eop_cnt_q, eop_cnt_d;
  logic              lvl_q, lvl_d;       // 1 = line at J, 0 = line at K
  logic              last_q, last_d;     // stuffed bit followed the final data bit
  logic [1:0]        line_q, line_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              nxt_lvl;

  // Next-state, NRZI level and registered line outputs.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    eop_cnt_d = eop_cnt_q;
    lvl_d     = lvl_q;
    last_d    = last_q;
    line_d    = line_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    nxt_lvl   = bit_in ? lvl_q : ~lvl_q;

    unique case (state_q)
      StIdle: begin
        line_d = LineJ;
        oe_d   = 1'b0;
        // The eop_done cycle still looks like idle but must not start a packet.
        if (pkt_start && !done_q) begin
          state_d = StActive;
          ones_d  = '0;
          lvl_d   = 1'b1;
        end
      end
      StActive: begin
        if (bit_valid) begin
          oe_d   = 1'b1;
          lvl_d  = nxt_lvl;
          line_d = nxt_lvl ? LineJ : LineK;
          ones_d = bit_in ? ones_q + 1'b1 : '0;
          if (bit_in && (ones_q == CntW'(STUFF_LEN - 1))) begin
            state_d = StStuff;
            last_d  = bit_last;
          end else if (bit_last) begin
            state_d   = StEop;
            eop_cnt_d = '0;
          end
        end
      end
      StStuff: begin
        lvl_d     = ~lvl_q;
        line_d    = lvl_q ? LineK : LineJ;
        ones_d    = '0;
        eop_cnt_d = '0;
        state_d   = last_q ? StEop : StActive;
      end
      StEop: begin
        if (eop_cnt_q < EopW'(EOP_SE0_CYCLES)) begin
          line_d    = LineSe0;
          eop_cnt_d = eop_cnt_q + 1'b1;
        end else if (eop_cnt_q == EopW'(EOP_SE0_CYCLES)) begin
          line_d    = LineJ;
          eop_cnt_d = eop_cnt_q + 1'b1;
        end else begin
          line_d  = LineJ;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          lvl_d   = 1'b1;
          ones_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset to idle J.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ones_q    <= '0;
      eop_cnt_q <= '0;
      lvl_q     <= 1'b1;
      last_q    <= 1'b0;
      line_q    <= LineJ;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      eop_cnt_q <= eop_cnt_d;
      lvl_q     <= lvl_d;
      last_q    <= last_d;
      line_q    <= line_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
    end
  end

  assign stall    = (state_q == StStuff);
  assign dp       = line_q[1];
  assign dm       = line_q[0];
  assign oe       = oe_q;
  assign eop_done = done_q;

`ifdef USB_TX_STUFF_CNT_EN
  logic [7:0] stuff_cnt_q;

  // Stuffed bits in the current packet, saturating, held after EOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      stuff_cnt_q <= '0;
    end else if (state_q == StIdle && pkt_start && !done_q) begin
      stuff_cnt_q <= '0;
    end else if (state_q == StStuff && stuff_cnt_q != 8'hff) begin
      stuff_cnt_q <= stuff_cnt_q + 8'd1;
    end
  end

  assign stuff_cnt = stuff_cnt_q;
`endif

endmodule
